// File: rtl/rj_serial_loader.sv
// Writer end of the Rj coefficient memory: deserialises an MSB-first framed
// serial stream into words and writes DEPTH consecutive entries per load.
module rj_serial_loader #(
    parameter int WORD_W = 16,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              Sclk,
    input  logic              Reset_n,
    input  logic              load_start,
    input  logic              Frame,
    input  logic              InputL,
    output logic              write_enable,
    output logic              mem_frame,
    output logic [ADDR_W-1:0] Write_Address,
    output logic [WORD_W-1:0] data_out,
    output logic              load_busy,
    output logic              load_done,
    output logic              frame_err
);

    localparam int BCW = $clog2(WORD_W + 1);
    localparam int WCW = ADDR_W + 1;
    localparam logic [BCW-1:0] BIT_ONE   = BCW'(1);
    localparam logic [BCW-1:0] BIT_FULL  = BCW'(WORD_W);
    localparam logic [WCW-1:0] WORD_ONE  = WCW'(1);
    localparam logic [WCW-1:0] LAST_WORD = WCW'(DEPTH - 1);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        WAIT_FRAME = 3'd1,
        SHIFT      = 3'd2,
        WRITE      = 3'd3,
        DONE       = 3'd4
    } state_t;

    state_t            state_r, state_s;
    logic [BCW-1:0]    bit_cnt_r, bit_cnt_s;
    logic [WCW-1:0]    word_cnt_r, word_cnt_s;
    logic [WORD_W-1:0] sr_r, sr_s;
    logic              we_r, we_s;
    logic [ADDR_W-1:0] addr_r, addr_s;
    logic [WORD_W-1:0] data_r, data_s;
    logic              busy_r, busy_s;
    logic              done_r, done_s;
    logic              err_r, err_s;
    logic              start_s;

    // A start is only honoured when no load is in progress.
    always_comb begin
        start_s = load_start && ((state_r == IDLE) || (state_r == DONE));
    end

    // Next-state and next-output logic; every register holds unless told otherwise.
    always_comb begin
        state_s    = state_r;
        bit_cnt_s  = bit_cnt_r;
        word_cnt_s = word_cnt_r;
        sr_s       = sr_r;
        we_s       = 1'b0;
        addr_s     = addr_r;
        data_s     = data_r;
        busy_s     = busy_r;
        done_s     = done_r;
        err_s      = err_r;

        case (state_r)
            IDLE, DONE: begin
                if (start_s) begin
                    state_s    = WAIT_FRAME;
                    word_cnt_s = {WCW{1'b0}};
                    bit_cnt_s  = {BCW{1'b0}};
                    busy_s     = 1'b1;
                    done_s     = 1'b0;
                    err_s      = 1'b0;
                end else begin
                    state_s = state_r;
                end
            end
            WAIT_FRAME: begin
                if (Frame) begin
                    sr_s      = {{(WORD_W-1){1'b0}}, InputL};
                    bit_cnt_s = BIT_ONE;
                    state_s   = SHIFT;
                end else begin
                    state_s = WAIT_FRAME;
                end
            end
            SHIFT: begin
                // The full word is presented to the memory one cycle after its LSB.
                if (bit_cnt_r == BIT_FULL) begin
                    state_s = WRITE;
                    we_s    = 1'b1;
                    addr_s  = word_cnt_r[ADDR_W-1:0];
                    data_s  = sr_r;
                end else if (Frame) begin
                    err_s     = 1'b1;
                    sr_s      = {{(WORD_W-1){1'b0}}, InputL};
                    bit_cnt_s = BIT_ONE;
                end else begin
                    sr_s      = {sr_r[WORD_W-2:0], InputL};
                    bit_cnt_s = bit_cnt_r + BIT_ONE;
                end
            end
            WRITE: begin
                word_cnt_s = word_cnt_r + WORD_ONE;
                if (word_cnt_r == LAST_WORD) begin
                    state_s = DONE;
                    busy_s  = 1'b0;
                    done_s  = 1'b1;
                end else if (Frame) begin
                    sr_s      = {{(WORD_W-1){1'b0}}, InputL};
                    bit_cnt_s = BIT_ONE;
                    state_s   = SHIFT;
                end else begin
                    state_s = WAIT_FRAME;
                end
            end
            default: begin
                state_s    = IDLE;
                bit_cnt_s  = {BCW{1'b0}};
                word_cnt_s = {WCW{1'b0}};
                busy_s     = 1'b0;
                done_s     = 1'b0;
            end
        endcase
    end

    // State, datapath and output registers.
    always_ff @(posedge Sclk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_r    <= IDLE;
            bit_cnt_r  <= {BCW{1'b0}};
            word_cnt_r <= {WCW{1'b0}};
            sr_r       <= {WORD_W{1'b0}};
            we_r       <= 1'b0;
            addr_r     <= {ADDR_W{1'b0}};
            data_r     <= {WORD_W{1'b0}};
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            err_r      <= 1'b0;
        end else begin
            state_r    <= state_s;
            bit_cnt_r  <= bit_cnt_s;
            word_cnt_r <= word_cnt_s;
            sr_r       <= sr_s;
            we_r       <= we_s;
            addr_r     <= addr_s;
            data_r     <= data_s;
            busy_r     <= busy_s;
            done_r     <= done_s;
            err_r      <= err_s;
        end
    end

    assign write_enable  = we_r;
    assign mem_frame     = we_r;
    assign Write_Address = addr_r;
    assign data_out      = data_r;
    assign load_busy     = busy_r;
    assign load_done     = done_r;
    assign frame_err     = err_r;

endmodule

// File: tb/tb_rj_serial_loader.sv
// Scoreboard bench for rj_serial_loader: expected writes are queued as words
// are driven and matched against memory-port strobes on the falling edge.
module tb_rj_serial_loader;

    logic        Sclk = 1'b0;
    logic        Reset_n = 1'b0;
    logic        load_start = 1'b0;
    logic        Frame = 1'b0;
    logic        InputL = 1'b0;
    logic        write_enable, mem_frame, load_busy, load_done, frame_err;
    logic [3:0]  Write_Address;
    logic [15:0] data_out;

    rj_serial_loader #(.WORD_W(16), .DEPTH(16), .ADDR_W(4)) dut (
        .Sclk(Sclk), .Reset_n(Reset_n), .load_start(load_start),
        .Frame(Frame), .InputL(InputL),
        .write_enable(write_enable), .mem_frame(mem_frame),
        .Write_Address(Write_Address), .data_out(data_out),
        .load_busy(load_busy), .load_done(load_done), .frame_err(frame_err)
    );

    always #5 Sclk = ~Sclk;

    int cyc = 0;
    always @(posedge Sclk) cyc <= cyc + 1;

    typedef struct {
        logic [3:0]  addr;
        logic [15:0] data;
        int          when;
    } exp_t;
    exp_t q[$];

    int         n_pass = 0;
    int         n_total = 0;
    logic [3:0] exp_addr = 4'd0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Every strobe must match the oldest outstanding expected write.
    always @(negedge Sclk) begin
        if (write_enable === 1'b1) begin
            if (q.size() == 0) begin
                check_val("unexpected_write", {31'd0, write_enable}, 32'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                check_val("wr_addr", {28'd0, Write_Address}, {28'd0, e.addr});
                check_val("wr_data", {16'd0, data_out}, {16'd0, e.data});
                check_val("wr_cycle", cyc, e.when);
                check_val("mem_frame", {31'd0, mem_frame}, 32'd1);
            end
        end
    end

    task automatic tick();
        @(posedge Sclk);
        #1;
    endtask

    task automatic idle(input int n);
        Frame = 1'b0;
        InputL = 1'b0;
        repeat (n) tick();
    endtask

    task automatic drive_bits(input logic [15:0] data, input int nbits, input int start_at);
        for (int i = 0; i < nbits; i++) begin
            Frame = (i == 0);
            InputL = data[15-i];
            load_start = (i == start_at);
            tick();
        end
        Frame = 1'b0;
        load_start = 1'b0;
    endtask

    // MSB sampled one edge after it is driven; strobe visible 16 edges later.
    task automatic send_word(input logic [15:0] data, input int start_at);
        int m;
        m = cyc;
        drive_bits(data, 16, start_at);
        q.push_back('{exp_addr, data, m + 17});
        exp_addr++;
    endtask

    task automatic start_load();
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        exp_addr = 4'd0;
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && q.size() > 0; i++) tick();
        check_val("drain", q.size(), 0);
    endtask

    task automatic check_status(input string tag, input logic busy, input logic done, input logic err);
        check_val({tag, "_busy"}, {31'd0, load_busy}, {31'd0, busy});
        check_val({tag, "_done"}, {31'd0, load_done}, {31'd0, done});
        check_val({tag, "_err"},  {31'd0, frame_err}, {31'd0, err});
    endtask

    task automatic check_all_zero(input string tag);
        check_status(tag, 1'b0, 1'b0, 1'b0);
        check_val({tag, "_we"},   {31'd0, write_enable}, 32'd0);
        check_val({tag, "_mf"},   {31'd0, mem_frame}, 32'd0);
        check_val({tag, "_addr"}, {28'd0, Write_Address}, 32'd0);
        check_val({tag, "_data"}, {16'd0, data_out}, 32'd0);
    endtask

    initial begin
        logic [15:0] w;
        repeat (3) tick();
        check_all_zero("reset");
        Reset_n = 1'b1;
        tick();

        // Serial activity before any start must not reach the memory.
        for (int i = 0; i < 24; i++) begin
            Frame = 1'($urandom_range(0, 1));
            InputL = 1'($urandom_range(0, 1));
            tick();
        end
        idle(3);
        check_status("prestart", 1'b0, 1'b0, 1'b0);

        // Load 1: first word A5C3, then words separated by idle gaps.
        start_load();
        check_status("start1", 1'b1, 1'b0, 1'b0);
        send_word(16'hA5C3, -1);
        idle(6);
        for (int i = 1; i < 16; i++) begin
            send_word(16'($urandom), -1);
            idle(6);
        end
        drain();
        check_status("done1", 1'b0, 1'b1, 1'b0);
        check_val("hold_addr", {28'd0, Write_Address}, 32'd15);

        // Load 2: back-to-back words, Frame in every write cycle.
        start_load();
        check_status("start2", 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) begin
            send_word(16'h1000 + 16'(i), -1);
            idle(1);
        end
        drain();
        idle(2);
        check_status("done2", 1'b0, 1'b1, 1'b0);
        check_val("hold_data", {16'd0, data_out}, 32'h0000100F);

        // Load 3: framing error in word 2, stray start pulse during word 5.
        start_load();
        send_word(16'h1111, -1);
        idle(1);
        send_word(16'h2222, -1);
        idle(1);
        drive_bits(16'hDEAD, 7, -1);
        send_word(16'hBEEF, -1);
        check_val("frame_err_set", {31'd0, frame_err}, 32'd1);
        idle(1);
        for (int i = 3; i < 16; i++) begin
            send_word(16'h3000 + 16'(i), (i == 5) ? 4 : -1);
            idle(1);
        end
        drain();
        idle(2);
        check_status("done3", 1'b0, 1'b1, 1'b1);

        // Restart from DONE clears the sticky flags.
        start_load();
        check_status("start4", 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            send_word(16'h4000 + 16'(i), -1);
            idle(1);
        end
        drive_bits(16'h5A5A, 9, -1);
        check_val("pre_reset_queue", q.size(), 0);
        Reset_n = 1'b0;
        #1;
        check_all_zero("midreset");
        tick();
        Reset_n = 1'b1;

        // Without a new start nothing is written.
        for (int i = 0; i < 2; i++) begin
            w = 16'($urandom);
            drive_bits(w, 16, -1);
            idle(1);
        end
        idle(3);
        check_status("postreset", 1'b0, 1'b0, 1'b0);

        start_load();
        send_word(16'hCAFE, -1);
        idle(1);
        drain();
        check_val("restart_addr", {28'd0, Write_Address}, 32'd0);
        check_status("final", 1'b1, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
